// File: rtl/hssi_lane_rst_seq.sv
// HSSI lane reset sequencer: steps the TX and RX analog/digital resets of a group of lanes
// through PLL lock and CDR lock, with timeout-driven retries and relock from DONE.
module hssi_lane_rst_seq #(
  parameter int unsigned        NUM_LN      = 4,
  parameter logic [NUM_LN-1:0]  LANE_MASK   = {NUM_LN{1'b1}},
  parameter int unsigned        T_ARST      = 16,
  parameter int unsigned        T_DRST      = 16,
  parameter int unsigned        LOCK_STABLE = 64,
  parameter int unsigned        TIMEOUT_CYC = 4096,
  parameter int unsigned        MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init_start,
  output logic              init_done,
  output logic              init_err,
  output logic [7:0]        retry_cnt,
  output logic [3:0]        seq_state,
  input  logic              tx_pll_locked,
  input  logic              tx_cal_busy,
  input  logic              rx_cal_busy,
  input  logic [NUM_LN-1:0] rx_is_lockedtodata,
  output logic [NUM_LN-1:0] tx_analogreset,
  output logic [NUM_LN-1:0] tx_digitalreset,
  output logic [NUM_LN-1:0] rx_analogreset,
  output logic [NUM_LN-1:0] rx_digitalreset
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;

  localparam logic [TW-1:0] LdArst    = TW'(T_ARST - 1);
  localparam logic [TW-1:0] LdDrst    = TW'(T_DRST - 1);
  localparam logic [TW-1:0] LdTimeout = TW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] StabLast  = SW'(LOCK_STABLE - 1);
  localparam logic [7:0]    RetryMax  = 8'(MAX_RETRY);

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StTxArst    = 4'd1,
    StTxWaitPll = 4'd2,
    StTxDrst    = 4'd3,
    StRxArst    = 4'd4,
    StRxWaitCdr = 4'd5,
    StRxDrst    = 4'd6,
    StDone      = 4'd7,
    StErr       = 4'd8
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d, timer_dec;
  logic [SW-1:0]     stab_q, stab_d;
  logic [7:0]        retry_q, retry_d;
  logic              timeout;
  logic              pll_ok, lanes_locked, cdr_ok;
  logic              tx_ar_en, tx_dr_en, rx_ar_en, rx_dr_en;
  logic [NUM_LN-1:0] tx_ar_q, tx_dr_q, rx_ar_q, rx_dr_q;
  logic              done_q, err_q;

  // Disabled lanes always count as locked so they never hold up the sequence.
  assign lanes_locked = &(rx_is_lockedtodata | ~LANE_MASK);
  assign cdr_ok       = lanes_locked & ~rx_cal_busy;
  assign pll_ok       = tx_pll_locked & ~tx_cal_busy;
  assign timer_dec    = (timer_q != '0) ? timer_q - TW'(1) : '0;

  always_comb begin
    state_d = state_q;
    stab_d  = '0;
    retry_d = retry_q;
    timeout = 1'b0;
    unique case (state_q)
      StIdle, StErr: begin
        if (init_start) begin
          state_d = StTxArst;
          retry_d = '0;
        end
      end
      StTxArst:    if (timer_q == '0) state_d = StTxWaitPll;
      StTxWaitPll: begin
        if (pll_ok)              state_d = StTxDrst;
        else if (timer_q == '0)  timeout = 1'b1;
      end
      StTxDrst:    if (timer_q == '0) state_d = StRxArst;
      StRxArst:    if (timer_q == '0) state_d = StRxWaitCdr;
      StRxWaitCdr: begin
        if (cdr_ok) begin
          if (stab_q == StabLast) state_d = StRxDrst;
          else                    stab_d  = stab_q + SW'(1);
        end
        if (state_d == StRxWaitCdr && timer_q == '0) timeout = 1'b1;
      end
      StRxDrst:    if (timer_q == '0) state_d = StDone;
      StDone: begin
        // A restart request takes priority over a simultaneous loss of lock.
        if (init_start) begin
          state_d = StTxArst;
          retry_d = '0;
        end else if (!lanes_locked) begin
          state_d = StRxWaitCdr;
        end
      end
      default:     state_d = StIdle;
    endcase

    if (timeout) begin
      stab_d = '0;
      if (retry_q < RetryMax) begin
        retry_d = retry_q + 8'd1;
        state_d = StTxArst;
      end else begin
        state_d = StErr;
      end
    end
  end

  // Shared timer reloads on every state change, otherwise counts down to zero.
  always_comb begin
    timer_d = timer_dec;
    if (state_d != state_q) begin
      unique case (state_d)
        StTxArst, StRxArst:       timer_d = LdArst;
        StTxDrst, StRxDrst:       timer_d = LdDrst;
        StTxWaitPll, StRxWaitCdr: timer_d = LdTimeout;
        default:                  timer_d = '0;
      endcase
    end
  end

  // Reset outputs are decoded from the next state so they move with the state register.
  always_comb begin
    tx_ar_en = 1'b1;
    tx_dr_en = 1'b1;
    rx_ar_en = 1'b1;
    rx_dr_en = 1'b1;
    unique case (state_d)
      StTxWaitPll, StTxDrst: tx_ar_en = 1'b0;
      StRxArst: begin
        tx_ar_en = 1'b0;
        tx_dr_en = 1'b0;
      end
      StRxWaitCdr, StRxDrst: begin
        tx_ar_en = 1'b0;
        tx_dr_en = 1'b0;
        rx_ar_en = 1'b0;
      end
      StDone: begin
        tx_ar_en = 1'b0;
        tx_dr_en = 1'b0;
        rx_ar_en = 1'b0;
        rx_dr_en = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      stab_q  <= '0;
      retry_q <= '0;
      tx_ar_q <= '1;
      tx_dr_q <= '1;
      rx_ar_q <= '1;
      rx_dr_q <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      stab_q  <= stab_d;
      retry_q <= retry_d;
      tx_ar_q <= {NUM_LN{tx_ar_en}} | ~LANE_MASK;
      tx_dr_q <= {NUM_LN{tx_dr_en}} | ~LANE_MASK;
      rx_ar_q <= {NUM_LN{rx_ar_en}} | ~LANE_MASK;
      rx_dr_q <= {NUM_LN{rx_dr_en}} | ~LANE_MASK;
      done_q  <= (state_d == StDone);
      err_q   <= (state_d == StErr);
    end
  end

  assign seq_state       = state_q;
  assign retry_cnt       = retry_q;
  assign init_done       = done_q;
  assign init_err        = err_q;
  assign tx_analogreset  = tx_ar_q;
  assign tx_digitalreset = tx_dr_q;
  assign rx_analogreset  = rx_ar_q;
  assign rx_digitalreset = rx_dr_q;

endmodule

// File: tb/tb_hssi_lane_rst_seq.sv
// Directed bench for hssi_lane_rst_seq: vector table for the nominal bring-up and relock,
// plus hand-written sequences for CDR glitch, retry/timeout, mid-sequence reset and lane masking.
module tb_hssi_lane_rst_seq;

  localparam int unsigned NL = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          init_start;
  logic          tx_pll_locked;
  logic          tx_cal_busy;
  logic          rx_cal_busy;
  logic [NL-1:0] rx_lock;
  logic [NL-1:0] lock_m;

  logic          init_done, init_err;
  logic [7:0]    retry_cnt;
  logic [3:0]    seq_state;
  logic [NL-1:0] txa, txd, rxa, rxd;

  logic          m_done, m_err;
  logic [7:0]    m_retry;
  logic [3:0]    m_state;
  logic [NL-1:0] m_txa, m_txd, m_rxa, m_rxd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hssi_lane_rst_seq #(
    .NUM_LN(4), .LANE_MASK(4'b1111), .T_ARST(4), .T_DRST(4),
    .LOCK_STABLE(8), .TIMEOUT_CYC(64), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .init_start(init_start),
    .init_done(init_done), .init_err(init_err), .retry_cnt(retry_cnt), .seq_state(seq_state),
    .tx_pll_locked(tx_pll_locked), .tx_cal_busy(tx_cal_busy), .rx_cal_busy(rx_cal_busy),
    .rx_is_lockedtodata(rx_lock),
    .tx_analogreset(txa), .tx_digitalreset(txd), .rx_analogreset(rxa), .rx_digitalreset(rxd)
  );

  hssi_lane_rst_seq #(
    .NUM_LN(4), .LANE_MASK(4'b0101), .T_ARST(4), .T_DRST(4),
    .LOCK_STABLE(8), .TIMEOUT_CYC(64), .MAX_RETRY(2)
  ) dut_m (
    .clk(clk), .reset_n(reset_n), .init_start(init_start),
    .init_done(m_done), .init_err(m_err), .retry_cnt(m_retry), .seq_state(m_state),
    .tx_pll_locked(tx_pll_locked), .tx_cal_busy(tx_cal_busy), .rx_cal_busy(rx_cal_busy),
    .rx_is_lockedtodata(lock_m),
    .tx_analogreset(m_txa), .tx_digitalreset(m_txd), .rx_analogreset(m_rxa),
    .rx_digitalreset(m_rxd)
  );

  // Masked instance: lanes 1 and 3 never lock and must keep their resets high.
  logic m_done_seen = 1'b0;
  logic mask_viol   = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if ((m_txa & 4'b1010) != 4'b1010 || (m_txd & 4'b1010) != 4'b1010 ||
          (m_rxa & 4'b1010) != 4'b1010 || (m_rxd & 4'b1010) != 4'b1010)
        mask_viol <= 1'b1;
      if (m_done) begin
        m_done_seen <= 1'b1;
        if (m_txa != 4'b1010 || m_txd != 4'b1010 || m_rxa != 4'b1010 || m_rxd != 4'b1010)
          mask_viol <= 1'b1;
      end
    end
  end

  function automatic logic [29:0] pack(input logic [3:0] st, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c,
                                       input logic [3:0] d, input logic dn, input logic er,
                                       input logic [7:0] rt);
    return {st, a, b, c, d, dn, er, rt};
  endfunction

  function automatic logic [29:0] cur();
    return pack(seq_state, txa, txd, rxa, rxd, init_done, init_err, retry_cnt);
  endfunction

  task automatic check(input string name, input logic [29:0] got, input logic [29:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned ncyc;
    logic        start;
    logic        pll;
    logic [3:0]  lock;
    logic [29:0] exp;
  } vec_t;

  function automatic vec_t mk(input int unsigned n, input logic s, input logic p,
                              input logic [3:0] l, input logic [3:0] st, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] c, input logic [3:0] d,
                              input logic dn);
    vec_t v;
    v.ncyc  = n;
    v.start = s;
    v.pll   = p;
    v.lock  = l;
    v.exp   = pack(st, a, b, c, d, dn, 1'b0, 8'd0);
    return v;
  endfunction

  localparam logic [29:0] IdleVals = {4'd0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 8'd0};

  task automatic wait_state(input string name, input logic [3:0] st, input int budget);
    logic found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (seq_state == st) found = 1'b1;
    end
    check(name, {29'd0, found}, 30'd1);
  endtask

  task automatic pulse_start();
    init_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init_start = 1'b0;
  endtask

  vec_t vecs[19];

  initial begin
    // Nominal bring-up (pll rises 10 cycles into TX_WAIT_PLL), loss of lock in DONE,
    // then restart colliding with loss of lock.
    vecs[0]  = mk(1,  1, 0, 4'hF, 4'd1, 4'hF, 4'hF, 4'hF, 4'hF, 0);
    vecs[1]  = mk(3,  0, 0, 4'hF, 4'd1, 4'hF, 4'hF, 4'hF, 4'hF, 0);
    vecs[2]  = mk(1,  0, 0, 4'hF, 4'd2, 4'h0, 4'hF, 4'hF, 4'hF, 0);
    vecs[3]  = mk(10, 0, 0, 4'hF, 4'd2, 4'h0, 4'hF, 4'hF, 4'hF, 0);
    vecs[4]  = mk(1,  0, 1, 4'hF, 4'd3, 4'h0, 4'hF, 4'hF, 4'hF, 0);
    vecs[5]  = mk(3,  0, 1, 4'hF, 4'd3, 4'h0, 4'hF, 4'hF, 4'hF, 0);
    vecs[6]  = mk(1,  0, 1, 4'hF, 4'd4, 4'h0, 4'h0, 4'hF, 4'hF, 0);
    vecs[7]  = mk(3,  0, 1, 4'hF, 4'd4, 4'h0, 4'h0, 4'hF, 4'hF, 0);
    vecs[8]  = mk(1,  0, 1, 4'hF, 4'd5, 4'h0, 4'h0, 4'h0, 4'hF, 0);
    vecs[9]  = mk(7,  0, 1, 4'hF, 4'd5, 4'h0, 4'h0, 4'h0, 4'hF, 0);
    vecs[10] = mk(1,  0, 1, 4'hF, 4'd6, 4'h0, 4'h0, 4'h0, 4'hF, 0);
    vecs[11] = mk(3,  0, 1, 4'hF, 4'd6, 4'h0, 4'h0, 4'h0, 4'hF, 0);
    vecs[12] = mk(1,  0, 1, 4'hF, 4'd7, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    vecs[13] = mk(1,  0, 1, 4'hE, 4'd5, 4'h0, 4'h0, 4'h0, 4'hF, 0);
    vecs[14] = mk(7,  0, 1, 4'hF, 4'd5, 4'h0, 4'h0, 4'h0, 4'hF, 0);
    vecs[15] = mk(1,  0, 1, 4'hF, 4'd6, 4'h0, 4'h0, 4'h0, 4'hF, 0);
    vecs[16] = mk(3,  0, 1, 4'hF, 4'd6, 4'h0, 4'h0, 4'h0, 4'hF, 0);
    vecs[17] = mk(1,  0, 1, 4'hF, 4'd7, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    vecs[18] = mk(1,  1, 1, 4'hE, 4'd1, 4'hF, 4'hF, 4'hF, 4'hF, 0);

    reset_n       = 1'b0;
    init_start    = 1'b0;
    tx_pll_locked = 1'b0;
    tx_cal_busy   = 1'b0;
    rx_cal_busy   = 1'b0;
    rx_lock       = 4'hF;
    lock_m        = 4'b0101;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_values", cur(), IdleVals);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("first_edge_after_reset", cur(), IdleVals);

    for (int i = 0; i < 19; i++) begin
      init_start    = vecs[i].start;
      tx_pll_locked = vecs[i].pll;
      rx_lock       = vecs[i].lock;
      repeat (vecs[i].ncyc) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), cur(), vecs[i].exp);
    end

    // Glitchy CDR: lane 2 drops for one cycle after 6 stable cycles.
    init_start = 1'b0;
    rx_lock    = 4'hF;
    wait_state("reach_rx_wait_cdr", 4'd5, 40);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rx_lock = 4'b1011;
    @(posedge clk);
    @(negedge clk);
    rx_lock = 4'hF;
    check("glitch_still_waiting", {26'd0, seq_state}, 30'd5);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("glitch_restart_hold", {26'd0, seq_state}, 30'd5);
    @(posedge clk);
    @(negedge clk);
    check("glitch_rx_drst", {26'd0, seq_state}, 30'd6);
    wait_state("reach_done_after_glitch", 4'd7, 20);

    // PLL never locks: two timed-out retries, then ERR.
    tx_pll_locked = 1'b0;
    pulse_start();
    check("restart_from_done", cur(), {4'd1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 8'd0});
    for (int r = 1; r <= 2; r++) begin
      wait_state($sformatf("reach_wait_pll_%0d", r), 4'd2, 10);
      repeat (63) @(posedge clk);
      @(negedge clk);
      check($sformatf("timeout_hold_%0d", r), {26'd0, seq_state}, 30'd2);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("retry_%0d", r), {18'd0, seq_state, retry_cnt}, {18'd0, 4'd1, 8'(r)});
    end
    wait_state("reach_err", 4'd8, 80);
    check("err_outputs", cur(), {4'd8, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 8'd2});
    pulse_start();
    check("restart_from_err", cur(), {4'd1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 8'd0});

    // One retry, then lock and abort with reset_n while in RX_WAIT_CDR.
    wait_state("reach_wait_pll_3", 4'd2, 10);
    repeat (64) @(posedge clk);
    @(negedge clk);
    check("retry_before_abort", {18'd0, seq_state, retry_cnt}, {18'd0, 4'd1, 8'd1});
    tx_pll_locked = 1'b1;
    wait_state("reach_cdr_before_abort", 4'd5, 40);
    check("cdr_retry_kept", {22'd0, retry_cnt}, 30'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_abort", cur(), IdleVals);
    @(negedge clk);
    reset_n = 1'b1;
    tx_pll_locked = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_after_abort", cur(), IdleVals);

    check("mask_reached_done", {29'd0, m_done_seen}, 30'd1);
    check("mask_bits_held", {29'd0, mask_viol}, 30'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hssi_lane_rst_seq.md
HSSI_LANE_RST_SEQ -- requirements
Module: hssi_lane_rst_seq

Interface
REQ-001 Parameters SHALL be:
- NUM_LN, default 4: number of HSSI lanes, range 1..16.
- LANE_MASK, default {NUM_LN{1'b1}}: 1 = lane enabled.
- T_ARST, default 16: analog reset hold, in cycles, ≥1.
- T_DRST, default 16: digital reset hold, in cycles, ≥1.
- LOCK_STABLE, default 64: cycles of continuous lock required, ≥1.
- TIMEOUT_CYC, default 4096: wait-state timeout, > LOCK_STABLE.
- MAX_RETRY, default 3: retries before error, 1..255.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: the only clock.
- reset_n, in, 1: asynchronous active-low reset.
- init_start, in, 1: start/restart request.
- init_done, out, 1: all enabled lanes up.
- init_err, out, 1: retries exhausted.
- retry_cnt, out, 8: retries used in the current attempt.
- seq_state, out, 4: state encoding, for debug.
- tx_pll_locked, in, 1: TX PLL lock.
- tx_cal_busy, in, 1: TX calibration in progress.
- rx_cal_busy, in, 1: RX calibration in progress.
- rx_is_lockedtodata, in, NUM_LN: per-lane CDR lock.
- tx_analogreset, out, NUM_LN: per-lane reset.
- tx_digitalreset, out, NUM_LN: per-lane reset.
- rx_analogreset, out, NUM_LN: per-lane reset.
- rx_digitalreset, out, NUM_LN: per-lane reset.

REQ-003 All inputs other than reset_n SHALL be synchronous to clk; the block SHALL contain no synchronisers.

Function
REQ-004 The FSM SHALL have these states and encodings: IDLE=0, TX_ARST=1, TX_WAIT_PLL=2, TX_DRST=3, RX_ARST=4, RX_WAIT_CDR=5, RX_DRST=6, DONE=7, ERR=8. seq_state SHALL equal the state register.

REQ-005 Every output SHALL be registered and decoded from next-state, so outputs change in the same cycle as the state register.

REQ-006 Per state, for enabled lanes:
- IDLE, TX_ARST, ERR: all four resets = 1.
- TX_WAIT_PLL, TX_DRST: tx_digitalreset = 1 and both RX resets = 1.
- RX_ARST: both RX resets = 1.
- RX_WAIT_CDR, RX_DRST: rx_digitalreset = 1.
- DONE: all resets = 0.

REQ-007 Reset bits of disabled lanes SHALL be 1 at all times, and their rx_is_lockedtodata SHALL be ignored.

REQ-008 init_start = 1 in IDLE, DONE or ERR SHALL move the FSM to TX_ARST, clear retry_cnt, init_done and init_err. init_start in any other state SHALL be ignored.

REQ-009 TX_ARST and RX_ARST SHALL each last exactly T_ARST cycles; TX_DRST and RX_DRST SHALL each last exactly T_DRST cycles. One shared down-counter of width $clog2(TIMEOUT_CYC+1) SHALL time all states and SHALL reload on every state entry.

REQ-010 TX_WAIT_PLL SHALL exit to TX_DRST in the cycle after tx_pll_locked = 1 and tx_cal_busy = 0 are first sampled together.

REQ-011 RX_WAIT_CDR SHALL exit to RX_DRST after LOCK_STABLE consecutive cycles in which every enabled lane has rx_is_lockedtodata = 1 and rx_cal_busy = 0.
- Any break in that condition SHALL restart the stability count.

REQ-012 If TX_WAIT_PLL or RX_WAIT_CDR runs TIMEOUT_CYC cycles without exiting:
- retry_cnt < MAX_RETRY: retry_cnt increments and the FSM goes to TX_ARST.
- otherwise: the FSM goes to ERR.

REQ-013 init_done SHALL be 1 exactly while in DONE. init_err SHALL be 1 exactly while in ERR.

REQ-014 In DONE, loss of lock on any enabled lane SHALL:
- move the FSM to RX_WAIT_CDR on the next cycle;
- deassert init_done on that cycle;
- leave the TX resets unchanged at 0;
- leave retry_cnt unchanged.

REQ-015 In DONE, if init_start and loss of lock occur in the same cycle, init_start SHALL win (REQ-008).

REQ-016 retry_cnt SHALL never exceed MAX_RETRY.

Reset
REQ-017 While reset_n = 0, and on the first clk edge after its release, the outputs SHALL be:
- state = IDLE;
- all reset outputs = all-ones;
- init_done = 0, init_err = 0;
- retry_cnt = 0, seq_state = 0;
- timer and stability counter = 0.

REQ-018 Assertion of reset_n mid-sequence SHALL abort immediately to the REQ-017 values without waiting for a clk edge.

Verification
Bench parameters: NUM_LN=4, T_ARST=4, T_DRST=4, LOCK_STABLE=8, TIMEOUT_CYC=64, MAX_RETRY=2.

REQ-019 Nominal bring-up:
- Stimulus: init_start pulse; pll_locked 10 cycles later; all lanes locked.
- Required: tx_analogreset high for exactly 4 cycles; init_done rises at 4+11+4+4+8+4 cycles; the 4 reset buses transition in the REQ-006 order.

REQ-020 PLL never locks:
- Required: two retries (retry_cnt 1 then 2), then ERR with init_err = 1 and all resets = 4'hF.
- Then init_start pulse: retry_cnt = 0 and the FSM is in TX_ARST.

REQ-021 Glitchy CDR:
- Stimulus: lane 2 lock drops for 1 cycle after 6 stable cycles.
- Required: the stability count restarts; RX_DRST is entered 8 cycles after the drop ends.

REQ-022 Loss of lock in DONE:
- Stimulus: lane 0 lock drops.
- Required: next cycle init_done = 0, rx_digitalreset = 4'hF, tx resets = 0; init_done re-rises after lock has been stable for 8 cycles plus 4 cycles of RX_DRST.

REQ-023 LANE_MASK = 4'b0101:
- Stimulus: lanes 1 and 3 never lock.
- Required: DONE is reached; reset bits 1 and 3 stay 1 throughout.

REQ-024 Mid-sequence reset:
- Stimulus: reset_n pulsed low in RX_WAIT_CDR.
- Required: all outputs at the REQ-017 values within the same cycle, with no clk edge needed.
